// File: rtl/div_job_sequencer.sv
// div_job_sequencer
// Queues divisor operands in a small FIFO and runs each one through an
// external divider with a START/DONE/AVAILABLE handshake. Each accepted
// request gets exactly one response, returned in request order. A zero
// operand is answered with an error without using the divider. A divider
// that does not finish within TIMEOUT cycles is abandoned and answered with
// an error.
//
// Ports
//   clk, rstn                      clock, synchronous active-low reset
//   req_valid/req_ready/req_data   operand request stream (ready = FIFO not full)
//   rsp_valid/rsp_ready            result stream handshake
//   rsp_data/rsp_err               result value and error flag
//   div_in/div_start               operand and START to the divider
//   div_done/div_available/div_out DONE, AVAILABLE and result from the divider
//   busy                           block not idle or FIFO non-empty
// All outputs are registered.

module div_job_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] div_in,
  output logic        div_start,
  input  logic        div_done,
  input  logic        div_available,
  input  logic [31:0] div_out,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RESPOND
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   div_in_q, div_in_d;
  logic                div_start_q, div_start_d;
  logic                busy_q, busy_d;

  logic                push;
  logic                pop;
  logic                timed_out;
  logic [DATA_W-1:0]   head;

  assign head      = mem_q[rd_ptr_q];
  // Budget runs out on the cycle that would be the TIMEOUT-th spent waiting.
  assign timed_out = (timer_q >= TMR_W'(TIMEOUT - 1));

  // Next-state, FIFO bookkeeping and registered output values.
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    timer_d     = timer_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    div_in_d    = div_in_q;
    div_start_d = div_start_q;
    push        = req_valid && req_ready_q;
    pop         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          if (head == '0) begin
            // Zero divisor is answered directly without touching the divider.
            pop         = 1'b1;
            rsp_data_d  = 32'hFFFF_FFFF;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = S_RESPOND;
          end else if (div_available) begin
            pop         = 1'b1;
            div_in_d    = head;
            div_start_d = 1'b1;
            timer_d     = '0;
            state_d     = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        timer_d = timer_q + TMR_W'(1);
        // Divider has latched the operand once it drops AVAILABLE.
        if (!div_available) begin
          div_start_d = 1'b0;
          state_d     = S_WAIT_DONE;
        end else if (timed_out) begin
          div_start_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESPOND;
        end
      end

      S_WAIT_DONE: begin
        timer_d = timer_q + TMR_W'(1);
        if (div_done) begin
          rsp_data_d  = div_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESPOND;
        end else if (timed_out) begin
          div_start_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESPOND;
        end
      end

      S_RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // FIFO pointers wrap naturally because DEPTH is a power of two.
    if (push) begin
      mem_d[wr_ptr_q] = req_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    req_ready_d = (count_d != CNT_W'(DEPTH));
    busy_d      = (state_d != S_IDLE) || (count_d != '0);
  end

  // State and output registers; FIFO storage needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rstn) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      div_in_q    <= '0;
      div_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      div_in_q    <= div_in_d;
      div_start_q <= div_start_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign div_in    = div_in_q;
  assign div_start = div_start_q;
  assign busy      = busy_q;

endmodule

// File: doc/div_job_sequencer.md
DIV_JOB_SEQUENCER -- requirements
Module: div_job_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the operand FIFO depth (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 63, SHALL be the maximum divider-wait cycles before abort.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  operand request valid.
REQ-006 req_ready  output  1  request accepted when req_valid and req_ready are both high on a clock edge.
REQ-007 req_data  input  32  divisor operand.
REQ-008 rsp_valid  output  1  result valid.
REQ-009 rsp_ready  input  1  result consumed when rsp_valid and rsp_ready are both high on a clock edge.
REQ-010 rsp_data  output  32  result value.
REQ-011 rsp_err  output  1  result is an error (zero operand or timeout).
REQ-012 div_in  output  32  operand driven to the divider.
REQ-013 div_start  output  1  divider START.
REQ-014 div_done  input  1  divider DONE.
REQ-015 div_available  input  1  divider AVAILABLE.
REQ-016 div_out  input  32  divider result.
REQ-017 busy  output  1  high whenever the state is not IDLE or the FIFO is non-empty.

Function
REQ-018 The block SHALL be the initiator of the divider START/DONE/AVAILABLE handshake; all outputs SHALL be registered.
REQ-019 FIFO: req_ready = !full; a push SHALL occur on accept; a pop SHALL occur only on IDLE exit; push and pop in the same cycle SHALL leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-020 States SHALL be IDLE, ISSUE, WAIT_DONE, RESPOND.
REQ-021 IDLE, FIFO non-empty, head != 0, div_available=1 -> pop head into div_in, div_start<=1, clear timer, go to ISSUE.
REQ-022 IDLE, FIFO non-empty, head == 0 -> pop head, skip the divider, rsp_data<=32'hFFFF_FFFF, rsp_err<=1, go to RESPOND.
REQ-023 IDLE, FIFO non-empty, head != 0, div_available=0 -> remain in IDLE with no pop.
REQ-024 ISSUE: hold div_start=1 and div_in stable until div_available=0 is sampled, then div_start<=0 and go to WAIT_DONE.
REQ-025 WAIT_DONE, div_done=1 -> rsp_data<=div_out, rsp_err<=0, go to RESPOND; div_start SHALL remain 0 so the divider can return to its idle state.
REQ-026 Timer: increments each cycle in ISSUE and WAIT_DONE; on reaching TIMEOUT without progress -> div_start<=0, rsp_data<=0, rsp_err<=1, go to RESPOND.
REQ-027 RESPOND: rsp_valid=1 with rsp_data and rsp_err held stable until rsp_ready; on the handshake, rsp_valid<=0 and go to IDLE.
REQ-028 Backpressure: while in RESPOND, the FIFO SHALL continue accepting requests until full.
REQ-029 Ordering: responses SHALL be returned in request order, exactly one response per accepted request.
REQ-030 Latency: with the FIFO empty and div_available=1, div_start SHALL rise 2 cycles after the accept edge; rsp_valid SHALL rise 1 cycle after div_done is sampled.
REQ-031 div_done sampled high in IDLE or ISSUE SHALL be ignored.

Reset
REQ-032 rstn=0 at a clock edge SHALL clear the FIFO, clear the timer, and force IDLE, including mid-transaction.
REQ-033 Reset values: req_ready=0 during reset and 1 from the first cycle after release; rsp_valid=0, rsp_data=0, rsp_err=0, div_in=0, div_start=0, busy=0.
REQ-034 A divider transaction aborted by reset SHALL produce no response; after reset, the block SHALL wait for div_available=1 before the next issue.

Verification
REQ-035 Single op: push 32'd4, divider model answers DONE after 16 cycles with div_out=32'h4000_0000 -> div_start high exactly 2 cycles after accept; rsp_data=32'h4000_0000, rsp_err=0.
REQ-036 Zero operand: push 0 -> div_start never asserted; rsp_data=32'hFFFF_FFFF, rsp_err=1.
REQ-037 Fill: push 5 operands back-to-back with DEPTH=4 while the divider is busy -> req_ready low after the 4th accept; 5 responses returned in order.
REQ-038 Timeout: divider model never asserts DONE -> after 63 cycles rsp_err=1, rsp_data=0, div_start=0; the next request is issued normally.
REQ-039 Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data and rsp_err stay stable, and no new div_start is issued.
REQ-040 Reset mid-op: assert rstn=0 during WAIT_DONE -> all outputs return to reset values next edge, no response is emitted, and the FIFO is empty.
